// File: rtl/memc_drain.sv
// memc_drain: output-side deskew and tile collector for a DIM x DIM systolic array.
//
// Row i of the array output leaves i cycles after row 0. This block delays row i
// by DIM-1-i enable-qualified stages so that a whole column of C lines up. It
// writes each aligned column into a tile buffer, then returns the tile one row
// per handshake over a valid/ready port.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   en           in   advances the delay lines and capture; 0 freezes input-side state
//   in_vld       in   tags the column element currently on c_in[0]
//   c_in         in   DIM x BITS_C, c_in[i] = row i of the array output
//   cap_ready    out  a tile buffer is free for capture
//   out_valid    out  out_row holds a valid C row
//   out_ready    in   consumer accepts out_row
//   out_row      out  DIM x BITS_C, out_row[c] = C[out_row_idx][c]
//   out_row_idx  out  index of the row on out_row
//   tile_done    out  1-cycle pulse on the handshake of row DIM-1
//   ovf          out  sticky: an aligned column arrived with no free buffer
//
// Build option
//   MEMC_DRAIN_DBUF_EN  two ping-pong tile buffers; capture fills one while the
//                       other drains. Without it a single buffer is used and
//                       cap_ready stays low for the whole drain.
//
// State per buffer
//   state   | meaning
//   S_CAP   | buffer free, accepting aligned columns
//   S_DRAIN | buffer full, rows being returned to the consumer

module memc_drain #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_vld,
  input  logic [DIM-1:0][BITS_C-1:0] c_in,
  output logic                       cap_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM-1:0][BITS_C-1:0] out_row,
  output logic [$clog2(DIM)-1:0]     out_row_idx,
  output logic                       tile_done,
  output logic                       ovf
);

  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] LAST = CW'(DIM-1);

  typedef enum logic {
    S_CAP   = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  typedef logic [DIM-1:0][BITS_C-1:0] row_t;

  logic wr_sel;
  logic rd_sel;

`ifdef MEMC_DRAIN_DBUF_EN
  localparam int NBUF = 2;
  logic wr_sel_q;
  logic rd_sel_q;
  assign wr_sel = wr_sel_q;
  assign rd_sel = rd_sel_q;
`else
  localparam int NBUF = 1;
  assign wr_sel = 1'b0;
  assign rd_sel = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Deskew: row i gets DIM-1-i stages; the last row needs none.
  // ---------------------------------------------------------------------------
  row_t           aligned;
  logic [DIM-2:0] vld_q;
  logic           avld;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_vld;
      for (int k = 1; k < DIM-1; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign avld = vld_q[DIM-2];

  for (genvar i = 0; i < DIM-1; i++) begin : g_dly
    localparam int L = DIM-1-i;
    logic [L-1:0][BITS_C-1:0] sh_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sh_q <= '0;
      end else if (en) begin
        sh_q[0] <= c_in[i];
        for (int k = 1; k < L; k++) begin
          sh_q[k] <= sh_q[k-1];
        end
      end
    end

    assign aligned[i] = sh_q[L-1];
  end

  assign aligned[DIM-1] = c_in[DIM-1];

  // ---------------------------------------------------------------------------
  // Tile buffers and per-buffer FSM
  // ---------------------------------------------------------------------------
  state_e          st_q [NBUF];
  row_t            buf_q [NBUF][DIM];
  logic [CW-1:0]   col_cnt_q;
  logic [CW-1:0]   row_cnt_q;
  logic            ovf_q;

  logic cap_fire;
  logic cap_drop;
  logic hs;

  // The write pointer always targets the buffer that was not filled most
  // recently, and drains happen oldest-first, so if that buffer is busy the
  // other one is busy too: checking only st_q[wr_sel] is enough.
  assign cap_fire = avld & en & (st_q[wr_sel] == S_CAP);
  assign cap_drop = avld & en & (st_q[wr_sel] != S_CAP);

  assign out_valid = (st_q[rd_sel] == S_DRAIN);
  assign hs        = out_valid & out_ready;
  assign tile_done = hs & (row_cnt_q == LAST);

`ifdef MEMC_DRAIN_DBUF_EN
  assign cap_ready = (st_q[0] == S_CAP) | (st_q[1] == S_CAP);
`else
  assign cap_ready = (st_q[0] == S_CAP);
`endif

  // Buffers are not reset; the gate on out_valid keeps stale contents off
  // the output, and a discarded partial tile is simply overwritten.
  assign out_row     = out_valid ? buf_q[rd_sel][row_cnt_q] : '0;
  assign out_row_idx = row_cnt_q;
  assign ovf         = ovf_q;

  always_ff @(posedge clk) begin
    if (cap_fire) begin
      for (int r = 0; r < DIM; r++) begin
        buf_q[wr_sel][r][col_cnt_q] <= aligned[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBUF; b++) begin
        st_q[b] <= S_CAP;
      end
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      ovf_q     <= 1'b0;
`ifdef MEMC_DRAIN_DBUF_EN
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
`endif
    end else begin
      if (cap_fire) begin
        if (col_cnt_q == LAST) begin
          st_q[wr_sel] <= S_DRAIN;
          col_cnt_q    <= '0;
`ifdef MEMC_DRAIN_DBUF_EN
          wr_sel_q     <= ~wr_sel_q;
`endif
        end else begin
          col_cnt_q <= col_cnt_q + CW'(1);
        end
      end

      // Dropped column: col_cnt_q is deliberately left alone.
      if (cap_drop) begin
        ovf_q <= 1'b1;
      end

      // cap_fire needs its buffer in S_CAP and hs needs its buffer in
      // S_DRAIN, so the two st_q writes never target the same entry.
      if (hs) begin
        if (row_cnt_q == LAST) begin
          st_q[rd_sel] <= S_CAP;
          row_cnt_q    <= '0;
`ifdef MEMC_DRAIN_DBUF_EN
          rd_sel_q     <= ~rd_sel_q;
`endif
        end else begin
          row_cnt_q <= row_cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
